paramest_nn_mul_pipe: RTL and testbench

Pipelined, multi-lane fixed-point multiplier for the ParamEst NN datapath. It is the successor to the single-stage combinational signed×unsigned multiplier, generalised as follows:
- runtime-free parametrised operand signedness
- lane count
- pipeline depth
- output requantisation (shift, round, saturate)
- valid/ready flow control
It sits between the layer accumulators' weight/activation fetch and the adder tree.

---
 rtl/paramest_nn_mul_pkg.sv | 46 ++++
 rtl/paramest_nn_mul_lane.sv | 107 ++++++++++
 rtl/paramest_nn_mul_pipe.sv | 82 ++++++++
 tb/tb_paramest_nn_mul_pipe.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/paramest_nn_mul_pkg.sv
// Shared types and the requantise helper for the ParamEst NN multiplier.
// The wide container keeps the rounding addend and the P+1-bit sum exact.
package paramest_nn_mul_pkg;

  localparam int MAX_W       = 64;
  localparam bit RND_TRUNC   = 1'b0;
  localparam bit RND_HALF_UP = 1'b1;
  localparam bit SAT_WRAP    = 1'b0;
  localparam bit SAT_CLAMP   = 1'b1;

  typedef struct packed {
    logic                    clamp;
    logic signed [MAX_W-1:0] val;
  } rq_t;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic rq_t sat_shift(input logic signed [MAX_W-1:0] prod, input int shift,
                                    input bit rnd, input bit sat, input int out_w);
    logic signed [MAX_W-1:0] sum;
    logic signed [MAX_W-1:0] r;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    rq_t res;
    sum = prod;
    if (rnd == RND_HALF_UP && shift > 0) sum = prod + (MAX_W'(1) << (shift - 1));
    r  = sum >>> shift;
    hi = (MAX_W'(1) << (out_w - 1)) - MAX_W'(1);
    lo = ~hi;
    res.clamp = 1'b0;
    res.val   = r;
    if (sat == SAT_CLAMP) begin
      if (r > hi) begin
        res.val   = hi;
        res.clamp = 1'b1;
      end else if (r < lo) begin
        res.val   = lo;
        res.clamp = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/paramest_nn_mul_lane.sv
// One multiplier lane: operand regs, product delay line, requantising output reg.
// Latency NUM_STAGE; every register loads only on its ld bit, otherwise holds (stall-safe).
module paramest_nn_mul_lane
  import paramest_nn_mul_pkg::*;
#(
  parameter int A_W       = 16,
  parameter int B_W       = 13,
  parameter bit B_SIGNED  = 1'b0,
  parameter int OUT_W     = 16,
  parameter int SHIFT     = 12,
  parameter bit ROUND     = 1'b1,
  parameter bit SAT       = 1'b1,
  parameter int NUM_STAGE = 2
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [NUM_STAGE-1:0] ld,
  input  logic [A_W-1:0]       din0,
  input  logic [B_W-1:0]       din1,
  output logic [OUT_W-1:0]     dout,
  output logic                 clamp
);

  localparam int P_W = prod_w(A_W, B_W);

  logic [A_W-1:0]      a_src;
  logic [B_W-1:0]      b_src;
  logic [P_W:0]        a_ext;
  logic [P_W:0]        b_ext;
  logic signed [P_W:0] prod;
  logic signed [P_W:0] fin_prod;
  rq_t                 rq;
  logic                unused_hi;
  logic [OUT_W-1:0]    dout_d;
  logic [OUT_W-1:0]    dout_q;

  // Both operands widened to P+1 bits so the truncated product is exact.
  always_comb begin
    a_ext = {{(B_W + 1){a_src[A_W-1]}}, a_src};
    b_ext = {{(A_W + 1){B_SIGNED ? b_src[B_W-1] : 1'b0}}, b_src};
    prod  = $signed(a_ext) * $signed(b_ext);
  end

  if (NUM_STAGE == 1) begin : g_comb
    assign a_src    = din0;
    assign b_src    = din1;
    assign fin_prod = prod;
  end else begin : g_pipe
    logic [A_W-1:0] a_d, a_q;
    logic [B_W-1:0] b_d, b_q;

    always_comb begin
      a_d = ld[0] ? din0 : a_q;
      b_d = ld[0] ? din1 : b_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end

    assign a_src = a_q;
    assign b_src = b_q;

    if (NUM_STAGE == 2) begin : g_n2
      assign fin_prod = prod;
    end else begin : g_deep
      logic signed [P_W:0] p_d [NUM_STAGE-2];
      logic signed [P_W:0] p_q [NUM_STAGE-2];

      always_comb begin
        p_d[0] = ld[1] ? prod : p_q[0];
        for (int k = 1; k < NUM_STAGE - 2; k++) p_d[k] = ld[k+1] ? p_q[k-1] : p_q[k];
      end

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          for (int k = 0; k < NUM_STAGE - 2; k++) p_q[k] <= '0;
        end else begin
          for (int k = 0; k < NUM_STAGE - 2; k++) p_q[k] <= p_d[k];
        end
      end

      assign fin_prod = p_q[NUM_STAGE-3];
    end
  end

  always_comb begin
    rq        = sat_shift(MAX_W'(fin_prod), SHIFT, ROUND, SAT, OUT_W);
    unused_hi = ^rq.val[MAX_W-1:OUT_W];
    dout_d    = ld[NUM_STAGE-1] ? rq.val[OUT_W-1:0] : dout_q;
    clamp     = rq.clamp;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) dout_q <= '0;
    else           dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/paramest_nn_mul_pipe.sv
// Multi-lane pipelined fixed-point multiplier with requantisation and sticky saturation flags.
// Latency NUM_STAGE, 1 beat/cycle; whole pipe freezes while the output beat is refused.
module paramest_nn_mul_pipe
  import paramest_nn_mul_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int A_W       = 16,
  parameter int B_W       = 13,
  parameter bit B_SIGNED  = 1'b0,
  parameter int OUT_W     = 16,
  parameter int SHIFT     = 12,
  parameter bit ROUND     = 1'b1,
  parameter bit SAT       = 1'b1,
  parameter int NUM_STAGE = 2
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*A_W-1:0]   din0,
  input  logic [LANES*B_W-1:0]   din1,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] dout,
  output logic [LANES-1:0]       sat_flag,
  input  logic                   sat_clr
);

  logic                 adv;
  logic [NUM_STAGE-1:0] nxt_vld;
  logic [NUM_STAGE-1:0] ld;
  logic [NUM_STAGE-1:0] vld_d;
  logic [NUM_STAGE-1:0] vld_q;
  logic [LANES-1:0]     clamp;
  logic [LANES-1:0]     sat_flag_d;
  logic [LANES-1:0]     sat_flag_q;

  // A stage loads exactly when the valid bit shifting into it is set and the pipe advances.
  always_comb begin
    adv        = ~(vld_q[NUM_STAGE-1] & ~out_ready);
    nxt_vld    = (vld_q << 1) | NUM_STAGE'(in_valid);
    ld         = adv ? nxt_vld : '0;
    vld_d      = adv ? nxt_vld : vld_q;
    sat_flag_d = (sat_clr ? '0 : sat_flag_q) | (ld[NUM_STAGE-1] ? clamp : '0);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      vld_q      <= '0;
      sat_flag_q <= '0;
    end else begin
      vld_q      <= vld_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[NUM_STAGE-1];
  assign sat_flag  = sat_flag_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    paramest_nn_mul_lane #(
      .A_W      (A_W),
      .B_W      (B_W),
      .B_SIGNED (B_SIGNED),
      .OUT_W    (OUT_W),
      .SHIFT    (SHIFT),
      .ROUND    (ROUND),
      .SAT      (SAT),
      .NUM_STAGE(NUM_STAGE)
    ) u_lane (
      .ap_clk  (ap_clk),
      .ap_rst_n(ap_rst_n),
      .ld      (ld),
      .din0    (din0[i*A_W +: A_W]),
      .din1    (din1[i*B_W +: B_W]),
      .dout    (dout[i*OUT_W +: OUT_W]),
      .clamp   (clamp[i])
    );
  end

endmodule

// File: tb/tb_paramest_nn_mul_pipe.sv
// Bench for paramest_nn_mul_pipe: directed vector table, multi-cycle corner sequences,
// and a randomized run scored against a plain-arithmetic reference.
module tb_paramest_nn_mul_pipe;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid, out_ready, sat_clr;
  logic [31:0] din0;
  logic [25:0] din1;
  logic        mon_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 ap_clk = ~ap_clk;

  logic rdy_def, ov_def, rdy_trn, ov_trn, rdy_uns, ov_uns, rdy_sgn, ov_sgn, rdy_n1, ov_n1, rdy_n3, ov_n3;
  logic [31:0] do_def, do_trn, do_n1, do_n3;
  logic [57:0] do_uns, do_sgn;
  logic [1:0]  sf_def, sf_trn, sf_uns, sf_sgn, sf_n1, sf_n3;

  paramest_nn_mul_pipe u_def (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy_def),
    .din0(din0), .din1(din1), .out_valid(ov_def), .out_ready(out_ready), .dout(do_def), .sat_flag(sf_def), .sat_clr(sat_clr));
  paramest_nn_mul_pipe #(.ROUND(0)) u_trn (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy_trn),
    .din0(din0), .din1(din1), .out_valid(ov_trn), .out_ready(out_ready), .dout(do_trn), .sat_flag(sf_trn), .sat_clr(sat_clr));
  paramest_nn_mul_pipe #(.SHIFT(0), .OUT_W(29), .SAT(0), .B_SIGNED(0)) u_uns (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(rdy_uns), .din0(din0), .din1(din1), .out_valid(ov_uns), .out_ready(out_ready),
    .dout(do_uns), .sat_flag(sf_uns), .sat_clr(sat_clr));
  paramest_nn_mul_pipe #(.SHIFT(0), .OUT_W(29), .SAT(0), .B_SIGNED(1)) u_sgn (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(rdy_sgn), .din0(din0), .din1(din1), .out_valid(ov_sgn), .out_ready(out_ready),
    .dout(do_sgn), .sat_flag(sf_sgn), .sat_clr(sat_clr));
  paramest_nn_mul_pipe #(.NUM_STAGE(1)) u_n1 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy_n1),
    .din0(din0), .din1(din1), .out_valid(ov_n1), .out_ready(out_ready), .dout(do_n1), .sat_flag(sf_n1), .sat_clr(sat_clr));
  paramest_nn_mul_pipe #(.NUM_STAGE(3), .SHIFT(8), .ROUND(0), .SAT(0)) u_n3 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(rdy_n3), .din0(din0), .din1(din1), .out_valid(ov_n3), .out_ready(out_ready),
    .dout(do_n3), .sat_flag(sf_n3), .sat_clr(sat_clr));

  typedef struct {
    logic [15:0] a0;
    logic [12:0] b0;
    logic [15:0] a1;
    logic [12:0] b1;
  } beat_t;

  typedef struct {
    beat_t       in;
    longint      def0, def1, trn0, trn1, uns0, sgn0;
    logic [1:0]  sat;
  } vec_t;

  beat_t q_def[$], q_n1[$], q_n3[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  function automatic longint sx16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sx29(input logic [28:0] v);
    return longint'($signed(v));
  endfunction

  // Reference: exact product, optional half-up rounding, floor shift, then clamp or wrap.
  function automatic longint model(input longint a, input longint b, input int sh, input bit rn,
                                   input bit sa, input int ow);
    longint p, hi, lo, m;
    p = a * b;
    if (rn && sh > 0) p = p + (longint'(1) << (sh - 1));
    p  = p >>> sh;
    hi = (longint'(1) << (ow - 1)) - 1;
    lo = -hi - 1;
    if (sa) begin
      if (p > hi) return hi;
      if (p < lo) return lo;
      return p;
    end
    m = longint'(1) << ow;
    p = p & (m - 1);
    if (p > hi) p = p - m;
    return p;
  endfunction

  function automatic logic [15:0] rnd_a();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [12:0] rnd_b();
    case ($urandom_range(0, 7))
      0:       return 13'h1FFF;
      1:       return 13'h0000;
      default: return 13'($urandom);
    endcase
  endfunction

  task automatic put_beat(input beat_t b);
    din0 = {b.a1, b.a0};
    din1 = {b.b1, b.b0};
  endtask

  function automatic beat_t cur_beat();
    beat_t b;
    b.a0 = din0[15:0];
    b.a1 = din0[31:16];
    b.b0 = din1[12:0];
    b.b1 = din1[25:13];
    return b;
  endfunction

  task automatic cmp_beat(input string nm, input beat_t b, input logic [31:0] d, input int sh,
                          input bit rn, input bit sa);
    chk({nm, "_lane0"}, sx16(d[15:0]),  model(sx16(b.a0), longint'(b.b0), sh, rn, sa, 16));
    chk({nm, "_lane1"}, sx16(d[31:16]), model(sx16(b.a1), longint'(b.b1), sh, rn, sa, 16));
  endtask

  // Scoreboard: negedge sees exactly the handshakes the next rising edge will perform.
  always @(negedge ap_clk) begin
    if (mon_en) begin
      if (ov_def && out_ready) begin
        chk("def_out_expected", longint'(q_def.size() != 0), 1);
        if (q_def.size() != 0) cmp_beat("rnd_def", q_def.pop_front(), do_def, 12, 1'b1, 1'b1);
      end
      if (ov_n1 && out_ready) begin
        chk("n1_out_expected", longint'(q_n1.size() != 0), 1);
        if (q_n1.size() != 0) cmp_beat("rnd_n1", q_n1.pop_front(), do_n1, 12, 1'b1, 1'b1);
      end
      if (ov_n3 && out_ready) begin
        chk("n3_out_expected", longint'(q_n3.size() != 0), 1);
        if (q_n3.size() != 0) cmp_beat("rnd_n3", q_n3.pop_front(), do_n3, 8, 1'b0, 1'b0);
      end
      if (in_valid && rdy_def) q_def.push_back(cur_beat());
      if (in_valid && rdy_n1)  q_n1.push_back(cur_beat());
      if (in_valid && rdy_n3)  q_n3.push_back(cur_beat());
    end
  end

  initial begin : main
    vec_t  vt[5];
    int    k;
    longint got[$];

    in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0; din0 = '0; din1 = '0;

    vt[0] = '{'{16'd1000, 13'd4096, 16'd0, 13'd0}, 1000, 0, 1000, 0, 4096000, -4096000, 2'b00};
    vt[1] = '{'{16'd3, 13'd2048, 16'hFFFD, 13'd2048}, 2, -1, 1, -2, 6144, 6144, 2'b00};
    vt[2] = '{'{16'd100, 13'h1FFF, 16'h8000, 13'h1FFF}, 200, -32768, 199, -32768, 819100, -100, 2'b10};
    vt[3] = '{'{16'h7FFF, 13'h1FFF, 16'hFFFF, 13'd1}, 32767, 0, 32767, -1, 268394497, -32767, 2'b01};
    vt[4] = '{'{16'h8000, 13'd0, 16'd16, 13'd4095}, 0, 16, 0, 15, 0, 0, 2'b00};

    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_out_valid", ov_def, 0);
    chk("rst_dout", do_def, 0);
    chk("rst_sat_flag", sf_def, 0);
    chk("rst_n1_valid", ov_n1, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    chk("rst_in_ready", rdy_def, 1);

    for (int v = 0; v < 5; v++) begin
      @(posedge ap_clk); #1;
      put_beat(vt[v].in);
      in_valid = 1'b1;
      @(negedge ap_clk);
      chk("vec_in_ready", rdy_def, 1);
      @(posedge ap_clk); #1;
      in_valid = 1'b0;
      chk("vec_lat1_novalid", ov_def, 0);
      @(posedge ap_clk); #1;
      chk("vec_lat2_valid", ov_def, 1);
      chk("vec_def0", sx16(do_def[15:0]), vt[v].def0);
      chk("vec_def1", sx16(do_def[31:16]), vt[v].def1);
      chk("vec_trn0", sx16(do_trn[15:0]), vt[v].trn0);
      chk("vec_trn1", sx16(do_trn[31:16]), vt[v].trn1);
      chk("vec_uns0", sx29(do_uns[28:0]), vt[v].uns0);
      chk("vec_sgn0", sx29(do_sgn[28:0]), vt[v].sgn0);
      chk("vec_sat_def", sf_def, vt[v].sat);
      chk("vec_sat_trn", sf_trn, vt[v].sat);
      chk("vec_sat_uns", sf_uns, 0);
      sat_clr = 1'b1;
      @(posedge ap_clk); #1;
      sat_clr = 1'b0;
      chk("vec_sat_clr", sf_def, 0);
    end

    // Clear and a saturating load on the same edge: the set must win.
    @(posedge ap_clk); #1;
    put_beat(vt[2].in);
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    sat_clr  = 1'b1;
    @(posedge ap_clk); #1;
    sat_clr = 1'b0;
    chk("sat_set_wins", sf_def, 2'b10);
    @(posedge ap_clk); #1;
    chk("sat_sticky", sf_def, 2'b10);
    sat_clr = 1'b1;
    @(posedge ap_clk); #1;
    sat_clr = 1'b0;
    chk("sat_clr_after", sf_def, 0);

    // Backpressure: 8 back-to-back beats, out_ready low in cycles 3..5.
    k = 0;
    for (int t = 0; t < 20; t++) begin
      @(posedge ap_clk); #1;
      out_ready = !(t >= 3 && t <= 5);
      in_valid  = (k < 8);
      din0      = {16'd0, 16'(k)};
      din1      = {13'd0, 13'd4096};
      @(negedge ap_clk);
      chk("bp_in_ready", rdy_def, (t >= 3 && t <= 5) ? 0 : 1);
      if (t >= 3 && t <= 5) chk("bp_hold_dout", sx16(do_def[15:0]), 1);
      if (ov_def && out_ready) got.push_back(sx16(do_def[15:0]));
      if (in_valid && rdy_def) k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", got.size(), 8);
    for (int i = 0; i < 8; i++) if (i < got.size()) chk("bp_order", got[i], i);

    // Reset with two beats in flight.
    @(posedge ap_clk); #1;
    din0 = {16'd0, 16'd5}; din1 = {13'd0, 13'd4096}; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    din0 = {16'd0, 16'd6};
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    @(negedge ap_clk);
    chk("mid_pre_valid", ov_def, 1);
    #1;
    ap_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ov_def, 0);
    chk("mid_rst_dout", do_def, 0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge ap_clk); #1;
      chk("mid_no_valid", ov_def, 0);
      chk("mid_no_valid_n3", ov_n3, 0);
    end

    // Randomized traffic scored by the negedge monitor.
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge ap_clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      din0      = {rnd_a(), rnd_a()};
      din1      = {rnd_b(), rnd_b()};
    end
    @(posedge ap_clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge ap_clk);
    #1;
    mon_en = 1'b0;
    chk("drain_def", q_def.size(), 0);
    chk("drain_n1", q_n1.size(), 0);
    chk("drain_n3", q_n3.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
